// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Double-buffered value, leading-zero blanking, minus sign, per-digit decimal points.
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        neg_in,
  input  logic        lz_en,
  input  logic        load,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  // state | meaning
  // DIG0  | scanning digit 0 (LSD)
  // DIG1  | scanning digit 1
  // DIG2  | scanning digit 2
  // DIG3  | scanning digit 3 (MSD / sign); leaving it is the frame boundary
  typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} digit_e;

  typedef struct packed {
    logic        neg;
    logic [3:0]  dpt;
    logic [15:0] val;
  } disp_t;

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hF;

  logic [PW-1:0] presc_q, presc_d;
  digit_e        idx_q, idx_d;
  disp_t         shadow_q, shadow_d;
  disp_t         active_q, active_d;
  logic          pending_q, pending_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    bcd_q, bcd_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          boundary;
  disp_t         load_word;
  logic [3:0]    nib [4];
  logic          lz_blank;
  logic [3:0]    code;

  assign tick       = en && (presc_q == PRESC_LAST);
  assign boundary   = tick && (idx_q == DIG3);
  assign load_word  = '{neg: neg_in, dpt: dp_in, val: value_in};
  assign frame_done = boundary;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      idx_q     <= DIG0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      an_q      <= 4'b1111;
      bcd_q     <= CODE_BLANK;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
    end
  end

  // Scan sequencing and the shadow/active handshake
  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (en) begin
      if (tick) begin
        presc_d = '0;
        idx_d   = digit_e'(idx_q + 2'd1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
      // The transfer uses the pre-load shadow; a coincident load stays pending.
      if (boundary && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      if (load) begin
        shadow_d  = load_word;
        pending_d = 1'b1;
      end
    end else begin
      // Display is dark, so there is nothing to tear: follow the latest value.
      if (load) begin
        shadow_d = load_word;
      end
      active_d  = load ? load_word : shadow_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nib[k] = active_q.val[4*k +: 4];
    end
    lz_blank = lz_en && (idx_q != DIG0);
    for (int k = 1; k < 4; k++) begin
      if ((k >= int'(idx_q)) && !((k == 3) && active_q.neg) && (nib[k] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
    if ((idx_q == DIG3) && active_q.neg) begin
      code = CODE_DASH;
    end else if (lz_blank) begin
      code = CODE_BLANK;
    end else begin
      code = nib[idx_q];
    end
  end

  always_comb begin
    an_d  = 4'b1111;
    dp_d  = 1'b1;
    bcd_d = CODE_BLANK;
    if (en) begin
      bcd_d = code;
      if (presc_q >= GUARD_END) begin
        an_d[idx_q] = 1'b0;
        dp_d        = ~active_q.dpt[idx_q];
      end
    end
  end

  assign an  = an_q;
  assign bcd = bcd_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;
  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        reset, en, load, neg_in, lz_en;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  bcd, an;
  logic        dp, frame_done;

  seg7_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk(clk), .reset(reset), .en(en), .value_in(value_in), .dp_in(dp_in),
    .neg_in(neg_in), .lz_en(lz_en), .load(load), .bcd(bcd), .an(an), .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position within the frame plus the two display buffers.
  int          m_pos  = 0;
  logic [15:0] m_sh_val = '0, m_ac_val = '0;
  logic [3:0]  m_sh_dp  = '0, m_ac_dp  = '0;
  logic        m_sh_neg = 1'b0, m_ac_neg = 1'b0, m_pend = 1'b0;
  logic        cur_lz   = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_code(input logic [15:0] v, input logic ng,
                                          input logic lz, input int i);
    int top;
    bit allz;
    if (ng && i == 3) return 4'hF;
    top  = ng ? 2 : 3;
    allz = 1'b1;
    if (lz && i >= 1) begin
      for (int k = i; k <= top; k++) begin
        if (4'((v >> (4 * k)) & 16'hF) != 4'h0) allz = 1'b0;
      end
      if (allz) return 4'hA;
    end
    return 4'((v >> (4 * i)) & 16'hF);
  endfunction

  task automatic step(input logic r, input logic e, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic ng, input logic lzv);
    int         slot, dig;
    logic [3:0] one_hot, e_an, e_bcd;
    logic       e_dp;
    @(negedge clk);
    reset = r; en = e; load = ld; value_in = v; dp_in = d; neg_in = ng; lz_en = lzv;
    #1;
    check_eq("frame_done", {15'd0, frame_done}, {15'd0, (e && m_pos == FRAME - 1)});
    slot    = m_pos % DIV;
    dig     = m_pos / DIV;
    one_hot = 4'b0001 << dig;
    e_an = 4'hF; e_bcd = 4'hA; e_dp = 1'b1;
    if (!r && e) begin
      e_bcd = ref_code(m_ac_val, m_ac_neg, lzv, dig);
      if (slot >= GRD) begin
        e_an = ~one_hot;
        e_dp = ~m_ac_dp[dig];
      end
    end
    if (r) begin
      m_pos = 0; m_pend = 1'b0;
      m_sh_val = '0; m_sh_dp = '0; m_sh_neg = 1'b0;
      m_ac_val = '0; m_ac_dp = '0; m_ac_neg = 1'b0;
    end else if (e) begin
      if (m_pos == FRAME - 1 && m_pend) begin
        m_ac_val = m_sh_val; m_ac_dp = m_sh_dp; m_ac_neg = m_sh_neg; m_pend = 1'b0;
      end
      if (ld) begin
        m_sh_val = v; m_sh_dp = d; m_sh_neg = ng; m_pend = 1'b1;
      end
      m_pos = (m_pos + 1) % FRAME;
    end else begin
      if (ld) begin
        m_sh_val = v; m_sh_dp = d; m_sh_neg = ng;
      end
      m_ac_val = m_sh_val; m_ac_dp = m_sh_dp; m_ac_neg = m_sh_neg; m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("an",  {12'd0, an},  {12'd0, e_an});
    check_eq("bcd", {12'd0, bcd}, {12'd0, e_bcd});
    check_eq("dp",  {15'd0, dp},  {15'd0, e_dp});
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b1, 1'b0, 16'($urandom), 4'($urandom), 1'($urandom), cur_lz);
  endtask

  task automatic put(input logic [15:0] v, input logic [3:0] d, input logic ng);
    step(1'b0, 1'b1, 1'b1, v, d, ng, cur_lz);
  endtask

  initial begin
    logic e_state;
    reset = 1'b1; en = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; neg_in = 1'b0; lz_en = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0);

    cur_lz = 1'b0;
    put(16'h1234, 4'h0, 1'b0);
    idle(80);
    cur_lz = 1'b1;
    put(16'h0050, 4'h0, 1'b0);
    idle(70);
    put(16'h0000, 4'h0, 1'b0);
    idle(70);
    put(16'h0007, 4'b0010, 1'b1);
    idle(70);

    // Tearing: load while scanning digit 1
    put(16'h1111, 4'h0, 1'b0);
    for (int c = 0; c < 2 * FRAME && !(m_pos / DIV == 1 && m_pos % DIV == 3); c++) idle(1);
    put(16'h2222, 4'h0, 1'b0);
    idle(70);

    // Load coinciding with the frame boundary
    for (int c = 0; c < FRAME && m_pos != FRAME - 1; c++) idle(1);
    put(16'h5678, 4'hF, 1'b0);
    idle(70);

    // Disable mid-slot, load during the dark period
    idle(5);
    for (int c = 0; c < 20; c++)
      step(1'b0, 1'b0, (c == 10), 16'h9999, 4'h0, 1'b0, cur_lz);
    idle(40);

    // Reset with a pending load while scanning digit 2
    for (int c = 0; c < FRAME && m_pos / DIV != 2; c++) idle(1);
    put(16'h4321, 4'h1, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0, cur_lz);
    idle(70);

    e_state = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      logic r, ld;
      logic [15:0] v;
      if ($urandom_range(0, 29) == 0) e_state = ~e_state;
      if ($urandom_range(0, 99) == 0) cur_lz = ~cur_lz;
      r  = ($urandom_range(0, 399) == 0);
      ld = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h00FF));
      step(r, e_state, ld, v, 4'($urandom), ($urandom_range(0, 3) == 0), cur_lz);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
- Drives one shared BCD-to-7-segment decoder through a single registered 4-bit code, and sequences the active-low digit anodes.
- Double-buffers the displayed value so a new value never tears mid-frame.
- Provides leading-zero blanking, minus-sign display and per-digit decimal points.
- Sits between the temperature datapath (value producer) and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ GUARD+2).
- GUARD, 16, cycles at the start of each slot during which all anodes are off (anti-ghosting).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  display enable
- value_in  in  16  four BCD digits; [15:12] is digit 3 (MSD), [3:0] is digit 0 (LSD)
- dp_in  in  4  decimal point request per digit, 1 = lit
- neg_in  in  1  1 = show minus sign in digit 3
- lz_en  in  1  1 = enable leading-zero blanking
- load  in  1  1-cycle strobe; captures value_in, dp_in and neg_in into the shadow register
- bcd  out  4  code to the shared decoder; 4'hA = blank, 4'hF = dash
- an  out  4  digit anodes, active-low
- dp  out  1  decimal point segment, active-low
- frame_done  out  1  1-cycle pulse at each frame boundary

Behaviour:
- Reset values: an=4'b1111, bcd=4'hA, dp=1, frame_done=0. Prescaler=0, digit index=0, shadow and active registers=0, pending=0.
- Prescaler counts 0..REFRESH_DIV-1. tick is asserted when the count equals REFRESH_DIV-1, after which the count wraps to 0.
- Digit index advances on tick: 0→1→2→3→0. The 3→0 wrap is the frame boundary.
- Load handshake:
  - load=1 writes the shadow register and sets pending.
  - At a frame boundary with pending=1, shadow is copied to active and pending is cleared.
  - A load in the same cycle as a boundary is applied at the following boundary; the boundary transfers the pre-load shadow.
  - Multiple loads before a boundary: the last one wins.
- frame_done pulses for 1 cycle on every frame boundary, regardless of pending.
- Digit code selection for the current index i, using the active register:
  - i=3 and neg=1 → 4'hF.
  - lz_en=1, i≥1, and all non-sign digits from the top down to i are 0 → 4'hA. When neg=1, the zero check starts at digit 2.
  - Otherwise → the raw digit nibble. Values above 9 pass through unchanged.
  - Digit 0 is never blanked.
- Anodes:
  - an[i]=0 only when prescaler ≥ GUARD; all other anodes are 1.
  - During the guard window an=4'b1111 and dp=1.
  - dp = ~dp_active[i] outside the guard window.
- Latency: an, bcd and dp are registered, updating 1 cycle after the prescaler/index state that selects them.
- en=0:
  - an=4'b1111, dp=1, bcd=4'hA.
  - Prescaler and index hold; frame_done stays 0.
  - load still writes shadow, and shadow copies directly to active every cycle (pending cleared).
- en 0→1: scanning resumes from the held index and count.
- reset mid-frame: all state returns to reset values on the next edge; a pending load is discarded.

Test Plan:
- Settings REFRESH_DIV=8, GUARD=2. After reset, load value_in=16'h1234, lz_en=0, en=1. Over the second frame, an walks 1110,1101,1011,0111 with bcd 4,3,2,1. Each anode is low for exactly 6 of 8 cycles; frame_done pulses every 32 cycles.
- lz_en=1, value 16'h0050 → digits 3,2 show bcd=A, digit 1 shows 5, digit 0 shows 0. Value 16'h0000 → A,A,A,0.
- neg_in=1, lz_en=1, value 16'h0007 → digit 3 shows F, digits 2,1 show A, digit 0 shows 7. dp_in=4'b0010 → dp=0 only during digit 1's lit window.
- Mid-frame tearing:
  - Frame showing 16'h1111; load 16'h2222 while index=1. Digits 2,3 of the current frame still show 1; the next frame shows all 2.
  - Load asserted exactly on the frame_done cycle → the new value appears one frame later.
- en=0 for 20 cycles mid-slot → an=1111; index and prescaler frozen. A load of 16'h9999 during en=0 → first lit digit after en=1 shows 9 immediately.
- Assert reset during index=2 → next cycle an=1111, bcd=A, dp=1. A pending load is lost, and the display shows 0 (digit 0 only when lz_en=1).
